mem_tag_responder: RTL and testbench

MEM_TAG_RESPONDER -- requirements
Module: mem_tag_responder

---
 rtl/mem_tag_responder.sv | 107 ++++++++++
 tb/tb_mem_tag_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_tag_responder.sv
// mem_tag_responder: tagged memory model with a fixed-latency in-order load
// return pipeline. Loads receive a nonzero 4-bit tag and return MEM_LATENCY
// edges later; stores write the backing store and produce no return.
module mem_tag_responder #(
    parameter int MEM_LATENCY = 4,
    parameter int MEM_WORDS   = 256,
    parameter int XLEN        = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      proc2mem_command,
    input  logic [XLEN-1:0] proc2mem_addr,
    input  logic [63:0]     proc2mem_data,
    output logic [3:0]      mem2proc_response,
    output logic [63:0]     mem2proc_data,
    output logic [3:0]      mem2proc_tag
);

    localparam int IDX_BITS = $clog2(MEM_WORDS);
    localparam int STAGES   = MEM_LATENCY;

    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    // Backing store; never reset, contents defined only by stores.
    logic [63:0] mem [MEM_WORDS];

    logic [3:0]  next_tag;
    logic [15:0] busy;

    // Stage 0 is written on the acceptance edge, stage STAGES drives the
    // outputs, so data appears exactly MEM_LATENCY edges after acceptance.
    // Empty slots carry tag 0 / data 0, which makes idle outputs zero.
    logic [STAGES:0]        vld_pipe;
    logic [STAGES:0][3:0]   tag_pipe;
    logic [STAGES:0][63:0]  data_pipe;

    logic [IDX_BITS-1:0] idx;
    logic                is_cmd;
    logic                accept_load;
    logic                accept_store;
    logic [15:0]         set_mask;
    logic [15:0]         clr_mask;

    // Offset bits and bits above the index alias onto the same word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{proc2mem_addr[2:0], proc2mem_addr[XLEN-1:3+IDX_BITS]};

    assign idx    = proc2mem_addr[3+IDX_BITS-1:3];
    assign is_cmd = (proc2mem_command == CMD_LOAD) || (proc2mem_command == CMD_STORE);

    // Grant the next tag unless it is still owned by an in-flight load;
    // reset forces a reject regardless of the command.
    always_comb begin
        mem2proc_response = 4'd0;
        if (reset && is_cmd && !busy[next_tag])
            mem2proc_response = next_tag;
    end

    assign accept_load  = (mem2proc_response != 4'd0) && (proc2mem_command == CMD_LOAD);
    assign accept_store = (mem2proc_response != 4'd0) && (proc2mem_command == CMD_STORE);

    // A load entering the output stage on this edge releases its tag; it can
    // never collide with the tag being granted, since a granted tag is idle.
    assign set_mask = accept_load ? (16'd1 << next_tag) : 16'd0;
    assign clr_mask = vld_pipe[STAGES-1] ? (16'd1 << tag_pipe[STAGES-1]) : 16'd0;

    // Tag allocator and busy tracking; tag 0 is skipped on wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            next_tag <= 4'd1;
            busy     <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
            if (mem2proc_response != 4'd0)
                next_tag <= (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
        end
    end

    // Return pipeline; load data is sampled before a same-edge store lands.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_pipe  <= '0;
            tag_pipe  <= '0;
            data_pipe <= '0;
        end else begin
            vld_pipe[0]  <= accept_load;
            tag_pipe[0]  <= accept_load ? next_tag : 4'd0;
            data_pipe[0] <= accept_load ? mem[idx] : 64'd0;
            for (int k = 1; k <= STAGES; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                tag_pipe[k]  <= tag_pipe[k-1];
                data_pipe[k] <= data_pipe[k-1];
            end
        end
    end

    // Store write port.
    always_ff @(posedge clock) begin
        if (accept_store)
            mem[idx] <= proc2mem_data;
    end

    assign mem2proc_tag  = tag_pipe[STAGES];
    assign mem2proc_data = data_pipe[STAGES];

endmodule

// File: tb/tb_mem_tag_responder.sv
// Directed bench for mem_tag_responder: one DUT at latency 4 for the main
// scenarios, one at latency 20 for tag-wrap back-pressure.
module tb_mem_tag_responder;

    localparam logic [1:0] NONE = 2'd0;
    localparam logic [1:0] LD   = 2'd1;
    localparam logic [1:0] ST   = 2'd2;

    logic        clock;
    logic        rst;
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [3:0]  resp_o, tag_o;
    logic [63:0] data_o;

    logic        rst20;
    logic [1:0]  cmd20;
    logic [31:0] addr20;
    logic [63:0] wdata20;
    logic [3:0]  resp20_o, tag20_o;
    logic [63:0] data20_o;

    logic [3:0]  resp, otag, r20, t20;
    logic [63:0] odata;

    int n_cmp = 0;
    int n_bad = 0;

    mem_tag_responder #(.MEM_LATENCY(4), .MEM_WORDS(256), .XLEN(32)) dut (
        .clock(clock), .reset(rst),
        .proc2mem_command(cmd), .proc2mem_addr(addr), .proc2mem_data(wdata),
        .mem2proc_response(resp_o), .mem2proc_data(data_o), .mem2proc_tag(tag_o)
    );

    mem_tag_responder #(.MEM_LATENCY(20), .MEM_WORDS(256), .XLEN(32)) dut20 (
        .clock(clock), .reset(rst20),
        .proc2mem_command(cmd20), .proc2mem_addr(addr20), .proc2mem_data(wdata20),
        .mem2proc_response(resp20_o), .mem2proc_data(data20_o), .mem2proc_tag(tag20_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One cycle: drive, sample the combinational grant mid-cycle, then
    // sample registered outputs just after the edge.
    task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
        cmd = c; addr = a; wdata = d;
        @(negedge clock); resp = resp_o;
        @(posedge clock); #1; otag = tag_o; odata = data_o;
    endtask

    task automatic step20(input logic [1:0] c);
        cmd20 = c; addr20 = 32'h0; wdata20 = 64'd0;
        @(negedge clock); r20 = resp20_o;
        @(posedge clock); #1; t20 = tag20_o;
    endtask

    task automatic test_reset();
        rst = 1'b0; rst20 = 1'b0;
        cmd = LD; addr = 32'h8; wdata = 64'd0;
        cmd20 = NONE; addr20 = 32'h0; wdata20 = 64'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_cmp++; if (resp_o !== 4'd0) begin n_bad++; $display("FAIL reset_resp: got %0d want 0", resp_o); end
        n_cmp++; if (tag_o !== 4'd0) begin n_bad++; $display("FAIL reset_tag: got %0d want 0", tag_o); end
        n_cmp++; if (data_o !== 64'd0) begin n_bad++; $display("FAIL reset_data: got %0d want 0", data_o); end
        @(posedge clock); #1;
        cmd = NONE; rst = 1'b1; rst20 = 1'b1;
    endtask

    task automatic test_store_load();
        step(ST, 32'h8, 64'd88);
        n_cmp++; if (resp !== 4'd1) begin n_bad++; $display("FAIL sl_store_resp: got %0d want 1", resp); end
        n_cmp++; if (otag !== 4'd0) begin n_bad++; $display("FAIL sl_store_tag: got %0d want 0", otag); end
        step(LD, 32'h8, 64'd0);
        n_cmp++; if (resp !== 4'd2) begin n_bad++; $display("FAIL sl_load_resp: got %0d want 2", resp); end
        n_cmp++; if (otag !== 4'd0) begin n_bad++; $display("FAIL sl_load_tag: got %0d want 0", otag); end
        for (int j = 1; j <= 5; j++) begin
            step(NONE, 32'h0, 64'd0);
            n_cmp++;
            if (otag !== ((j == 4) ? 4'd2 : 4'd0) || odata !== ((j == 4) ? 64'd88 : 64'd0)) begin
                n_bad++;
                $display("FAIL sl_return[%0d]: got tag %0d data %0d want tag %0d data %0d",
                         j, otag, odata, (j == 4) ? 2 : 0, (j == 4) ? 88 : 0);
            end
        end
    endtask

    task automatic test_load_then_store();
        step(LD, 32'h8, 64'd0);
        n_cmp++; if (resp !== 4'd3) begin n_bad++; $display("FAIL lts_load_resp: got %0d want 3", resp); end
        step(ST, 32'h8, 64'd5);
        n_cmp++; if (resp !== 4'd4) begin n_bad++; $display("FAIL lts_store_resp: got %0d want 4", resp); end
        repeat (3) step(NONE, 32'h0, 64'd0);
        n_cmp++; if (otag !== 4'd3 || odata !== 64'd88) begin n_bad++; $display("FAIL lts_old_value: got tag %0d data %0d want tag 3 data 88", otag, odata); end
        step(LD, 32'h8, 64'd0);
        n_cmp++; if (resp !== 4'd5) begin n_bad++; $display("FAIL lts_reload_resp: got %0d want 5", resp); end
        repeat (4) step(NONE, 32'h0, 64'd0);
        n_cmp++; if (otag !== 4'd5 || odata !== 64'd5) begin n_bad++; $display("FAIL lts_new_value: got tag %0d data %0d want tag 5 data 5", otag, odata); end
    endtask

    task automatic test_alias();
        step(ST, 32'h808, 64'd7);
        n_cmp++; if (resp !== 4'd6) begin n_bad++; $display("FAIL alias_store_resp: got %0d want 6", resp); end
        step(LD, 32'h008, 64'd0);
        n_cmp++; if (resp !== 4'd7) begin n_bad++; $display("FAIL alias_load_resp: got %0d want 7", resp); end
        repeat (4) step(NONE, 32'h0, 64'd0);
        n_cmp++; if (otag !== 4'd7 || odata !== 64'd7) begin n_bad++; $display("FAIL alias_return: got tag %0d data %0d want tag 7 data 7", otag, odata); end
    endtask

    task automatic test_reset_midflight();
        // Words 0..15 hold 100+i for the back-to-back check that follows.
        for (int i = 0; i < 16; i++) step(ST, 32'(i * 8), 64'(100 + i));
        for (int i = 0; i < 3; i++) begin
            step(LD, 32'(i * 8), 64'd0);
            n_cmp++; if (resp === 4'd0) begin n_bad++; $display("FAIL mid_load_resp[%0d]: got 0 want nonzero", i); end
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(LD, 32'h8, 64'd0);
            n_cmp++; if (resp !== 4'd0 || otag !== 4'd0) begin n_bad++; $display("FAIL mid_in_reset[%0d]: got resp %0d tag %0d want 0 0", i, resp, otag); end
        end
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(NONE, 32'h0, 64'd0);
            n_cmp++; if (otag !== 4'd0) begin n_bad++; $display("FAIL mid_stale_tag[%0d]: got %0d want 0", i, otag); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  exp_t;
        logic [63:0] exp_d;
        for (int j = 0; j < 20; j++) begin
            if (j < 16) step(LD, 32'(j * 8), 64'd0);
            else        step(NONE, 32'h0, 64'd0);
            if (j < 16) begin
                exp_t = (j < 15) ? 4'(j + 1) : 4'd1;
                n_cmp++; if (resp !== exp_t) begin n_bad++; $display("FAIL b2b_resp[%0d]: got %0d want %0d", j, resp, exp_t); end
            end
            if (j >= 4) begin
                exp_t = (j - 4 < 15) ? 4'(j - 3) : 4'd1;
                exp_d = 64'(100 + j - 4);
            end else begin
                exp_t = 4'd0;
                exp_d = 64'd0;
            end
            n_cmp++;
            if (otag !== exp_t || odata !== exp_d) begin
                n_bad++;
                $display("FAIL b2b_return[%0d]: got tag %0d data %0d want tag %0d data %0d", j, otag, odata, exp_t, exp_d);
            end
        end
    endtask

    task automatic test_latency20_wrap();
        int         rej;
        logic [3:0] granted;
        logic [3:0] seen;
        rej = 0; granted = 4'd0; seen = 4'd0;
        for (int i = 0; i < 15; i++) begin
            step20(LD);
            n_cmp++; if (r20 !== 4'(i + 1)) begin n_bad++; $display("FAIL l20_resp[%0d]: got %0d want %0d", i, r20, i + 1); end
        end
        for (int s = 15; s < 60; s++) begin
            step20(LD);
            if (s == 20) seen = t20;
            if (r20 !== 4'd0) begin
                granted = r20;
                break;
            end
            rej++;
        end
        cmd20 = NONE;
        n_cmp++; if (rej != 6) begin n_bad++; $display("FAIL l20_reject_cycles: got %0d want 6", rej); end
        n_cmp++; if (granted !== 4'd1) begin n_bad++; $display("FAIL l20_wrap_grant: got %0d want 1", granted); end
        n_cmp++; if (seen !== 4'd1) begin n_bad++; $display("FAIL l20_first_return: got %0d want 1", seen); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_load_then_store();
        test_alias();
        test_reset_midflight();
        test_back_to_back();
        test_latency20_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
